// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
//
// Shared definitions for the serial pattern detector (seq_detect_fsm).
//
// Contents:
//   - MAX_LEN / state_width()   : sizing helpers for the matched-prefix state
//   - state_vec_t               : widest possible state vector (MAX_LEN pattern)
//   - overlap_mode_e            : decoded meaning of the overlap input
//   - prefix_fail()             : longest proper prefix of the pattern that is
//                                 also a suffix (KMP failure value of LEN)
//   - next_state()              : KMP automaton transition delta(s, b)
//
// All functions are evaluated at elaboration time only; they build the
// transition constants and never turn into runtime logic on their own.
// Patterns are passed zero-extended to 32 bits, MSB of the LEN-bit pattern
// is the first bit received.
// -----------------------------------------------------------------------------
package seq_detect_pkg;

    localparam int MAX_LEN = 32;

    // Number of bits needed to hold a matched-prefix length in 0..len.
    function automatic int state_width(input int len);
        return $clog2(len + 1);
    endfunction

    localparam int STATE_W_MAX = state_width(MAX_LEN);

    typedef logic [STATE_W_MAX-1:0] state_vec_t;

    typedef enum logic {
        MODE_NON_OVERLAP = 1'b0,
        MODE_OVERLAP     = 1'b1
    } overlap_mode_e;

    // Longest proper prefix of the pattern that is also a suffix of it.
    // Prefix bit j is pat[len-1-j]; suffix of length k read MSB-first is
    // pat[k-1] .. pat[0], so its bit j is pat[k-1-j].
    function automatic int prefix_fail(input logic [31:0] pat, input int len);
        int   best;
        logic ok;
        best = 0;
        for (int k = 1; k < MAX_LEN; k++) begin
            if (k < len) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_LEN; j++) begin
                    if (j < k) begin
                        if (pat[5'(len - 1 - j)] != pat[5'(k - 1 - j)]) begin
                            ok = 1'b0;
                        end else begin
                            ok = ok;
                        end
                    end else begin
                        ok = ok;
                    end
                end
                if (ok) begin
                    best = k;
                end else begin
                    best = best;
                end
            end else begin
                best = best;
            end
        end
        return best;
    endfunction

    // KMP transition: the longest prefix of the pattern that is a suffix of
    // (first s pattern bits followed by b). Valid for s in 0..len-1.
    // Candidate lengths are tried in ascending order so the last hit wins.
    function automatic int next_state(input int s, input logic b,
                                      input logic [31:0] pat, input int len);
        int   best;
        int   idx;
        logic ok;
        logic seq_bit;
        best = 0;
        for (int k = 1; k <= MAX_LEN; k++) begin
            if ((k <= s + 1) && (k <= len)) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_LEN; j++) begin
                    if (j < k) begin
                        // Position inside the (s+1)-bit sequence being matched.
                        idx = s + 1 - k + j;
                        if (idx < s) begin
                            seq_bit = pat[5'(len - 1 - idx)];
                        end else begin
                            seq_bit = b;
                        end
                        if (seq_bit != pat[5'(len - 1 - j)]) begin
                            ok = 1'b0;
                        end else begin
                            ok = ok;
                        end
                    end else begin
                        ok = ok;
                    end
                end
                if (ok) begin
                    best = k;
                end else begin
                    best = best;
                end
            end else begin
                best = best;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detect_fsm_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter with synchronous clear. Used by seq_detect_fsm to
// count detected matches when SEQ_DETECT_MATCH_COUNT_EN is defined.
//
// Ports:
//   clk_i   : rising-edge clock
//   rst_ni  : asynchronous active-low reset (count -> 0)
//   clr_i   : synchronous clear, dominates inc_i
//   inc_i   : add one on this edge unless already at all-ones
//   cnt_o   : current count, registered
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max_s;

    assign at_max_s = &cnt_q;

    // Next count: clear first, then saturating increment, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc_i && !at_max_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_fsm.sv
// -----------------------------------------------------------------------------
// seq_detect_fsm
//
// Generic serial pattern detector built on a KMP automaton. One bit of din is
// consumed on each rising edge where en=1. The state register holds the length
// of the longest pattern prefix matched so far (0..LEN).
//
// Parameters:
//   LEN      : pattern length, 2..32
//   PATTERN  : LEN-bit pattern, MSB received first
//   CNT_W    : match counter width (only meaningful with the counter option)
//
// Ports:
//   clk        : rising-edge clock
//   n_reset    : asynchronous active-low reset
//   din        : serial data bit
//   en         : sample enable
//   clr        : synchronous clear of state and counter (beats en)
//   overlap    : 1 = overlapping detection, 0 = restart after each match
//   state      : matched-prefix length
//   match      : Moore flag, state == LEN
//   hit        : Mealy look-ahead, current bit completes the pattern
//   match_cnt  : saturating count of hits
//
// Build option:
//   SEQ_DETECT_MATCH_COUNT_EN : when defined, a sat_counter counts every hit.
//                               When undefined, match_cnt is tied to zero and
//                               no counter flops exist.
// -----------------------------------------------------------------------------
module seq_detect_fsm
    import seq_detect_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int             CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       din,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       overlap,
    output logic [$clog2(LEN+1)-1:0]   state,
    output logic                       match,
    output logic                       hit,
    output logic [CNT_W-1:0]           match_cnt
);

    localparam int          SW       = state_width(LEN);
    localparam int          NS       = 2 ** SW;
    localparam logic [31:0] PAT_EXT  = 32'(PATTERN);
    localparam int          FAIL_LEN = prefix_fail(PAT_EXT, LEN);

    typedef logic [SW-1:0] state_t;

    localparam state_t ST_FULL = state_t'(LEN);
    localparam state_t ST_IDLE = state_t'(0);

    state_t        state_q;
    state_t        state_d;
    state_t        next_s;
    logic          illegal_s;
    logic          hit_s;
    overlap_mode_e mode_s;

    // Transition constants, one row per encodable state. The two tables only
    // differ in the full-match row; rows above LEN are unreachable encodings
    // and fall back to idle.
    state_t tbl_ovl_s [NS][2];
    state_t tbl_nov_s [NS][2];

    for (genvar gs = 0; gs < NS; gs++) begin : g_row
        for (genvar gb = 0; gb < 2; gb++) begin : g_col
            if (gs < LEN) begin : g_prefix
                assign tbl_ovl_s[gs][gb] = state_t'(next_state(gs, (gb == 1), PAT_EXT, LEN));
                assign tbl_nov_s[gs][gb] = state_t'(next_state(gs, (gb == 1), PAT_EXT, LEN));
            end else if (gs == LEN) begin : g_full
                // Overlapping: keep the longest border of the pattern.
                assign tbl_ovl_s[gs][gb] = state_t'(next_state(FAIL_LEN, (gb == 1), PAT_EXT, LEN));
                // Non-overlapping: behave as if starting fresh.
                assign tbl_nov_s[gs][gb] = state_t'(next_state(0, (gb == 1), PAT_EXT, LEN));
            end else begin : g_illegal
                assign tbl_ovl_s[gs][gb] = ST_IDLE;
                assign tbl_nov_s[gs][gb] = ST_IDLE;
            end
        end
    end

    assign mode_s    = overlap_mode_e'(overlap);
    assign illegal_s = (state_q > ST_FULL);

    // Successor for the current bit; overlap only matters in the full row,
    // since both tables agree everywhere else.
    always_comb begin
        next_s = tbl_nov_s[state_q][din];
        case (mode_s)
            MODE_OVERLAP:     next_s = tbl_ovl_s[state_q][din];
            MODE_NON_OVERLAP: next_s = tbl_nov_s[state_q][din];
            default:          next_s = tbl_nov_s[state_q][din];
        endcase
    end

    // Next state: clear, then recovery from illegal encodings, then enable.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else if (illegal_s) begin
            state_d = ST_IDLE;
        end else if (en) begin
            state_d = next_s;
        end else begin
            state_d = state_q;
        end
    end

    // Matched-prefix state register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Look-ahead flag; gated by n_reset so it cannot glitch high during reset.
    assign hit_s = n_reset & en & ~clr & (next_s == ST_FULL);

    assign state = state_q;
    assign match = (state_q == ST_FULL);
    assign hit   = hit_s;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk_i  (clk),
        .rst_ni (n_reset),
        .clr_i  (clr),
        .inc_i  (hit_s),
        .cnt_o  (match_cnt)
    );
`else
    assign match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/seq_detect_fsm.md
Name: seq_detect_fsm

Overview:
- Parametrised synchronous serial pattern detector: the next generation of the lab's 2-bit gate-level state machine.
- Samples one serial bit per enabled clock.
- Tracks the longest matched prefix of a compile-time pattern and exposes that state.
- Gives a registered (Moore) match flag, a combinational look-ahead (Mealy) hit, and a selectable overlap mode.
- Used as the generic sequence-recogniser behind lab front-ends; replaces hand-built per-pattern FSMs.

Parameters:
- LEN, 4, pattern length in bits; legal range 2..32.
- PATTERN, 4'b1011, LEN-bit pattern; MSB is received first.
- CNT_W, 8, width of the match counter (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- n_reset  input  1  asynchronous active-low reset.
- din  input  1  serial data bit.
- en  input  1  sample enable; din is consumed only when en=1.
- clr  input  1  synchronous clear of state (and counter).
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- state  output  $clog2(LEN+1)  matched-prefix length, 0..LEN.
- match  output  1  Moore flag: state==LEN.
- hit  output  1  Mealy flag: current en/din will complete the pattern at the next edge.
- match_cnt  output  CNT_W  saturating match count (MATCH_COUNT_EN only).

Behaviour:
- Reset (n_reset=0, asynchronous): state=0, match=0, match_cnt=0. hit is forced 0 while in reset.
- Transition function delta(s,b), for s<LEN: the longest prefix of PATTERN that is a suffix of (first s bits of PATTERN followed by b), i.e. KMP automaton.
  - The table is computed at elaboration from PATTERN; no runtime table RAM.
- From s==LEN:
  - overlap=1: delta(fail(LEN), b), where fail(LEN) is the longest proper prefix of PATTERN that is also its suffix.
  - overlap=0: delta(0, b).
- Per rising edge, priority clr > en:
  - clr=1: state<=0.
  - else en=1: state<=next.
  - else: state holds.
- match = (state==LEN), purely decoded from the state register. It is high exactly one cycle per match unless the next enabled bit re-completes the pattern. Latency: the final pattern bit sampled at edge k gives match=1 after edge k.
- hit = en & ~clr & (next==LEN); combinational, same cycle as the final bit.
- overlap is sampled only when leaving state LEN; changing it at any other time has no effect.
- en=0 with state==LEN: match stays high; no extra count.
- Reset mid-stream: the partial prefix is discarded; detection restarts from state 0 after release.
- Illegal state encodings (>LEN) go to 0 on the next edge regardless of en.

Optional Feature:
- SEQ_DETECT_MATCH_COUNT_EN defined:
  - match_cnt increments on every edge where hit=1.
  - Saturates at 2^CNT_W-1.
  - Cleared by clr and by reset.
  - clr and hit in the same cycle: clr wins and the count is 0.
- Undefined: match_cnt port is driven constant 0 and no counter flops are inferred.

Decomposition:
- Package seq_detect_pkg:
  - elaboration functions prefix_fail(PATTERN,LEN) and next_state(s,b,PATTERN,LEN);
  - localparam helpers for state width;
  - typedef of the state vector, parametrised through a width constant.
- Sub-module sat_counter (CNT_W; inc, clr): instantiated only under SEQ_DETECT_MATCH_COUNT_EN.

Test Plan:
- Default pattern 1011, overlap=1, en=1; stream 1,0,1,1,0,1,1:
  - hit high with the 4th and 7th bits;
  - match high after edges 4 and 7;
  - state sequence 1,2,3,4,2,3,4.
- Same stream with overlap=0:
  - single match after edge 4;
  - state after 7th bit = 1;
  - match_cnt=1.
- en toggled low for 3 cycles between bits 2 and 3 of 1011: state holds at 2, hit=0; the match still occurs after the 4th enabled bit.
- clr asserted together with the final bit 1 at state 3: state=0, hit=0, match stays 0, counter unchanged.
- n_reset pulsed low mid-cycle at state 3: state=0 and match=0 immediately; a subsequent full 1011 is detected normally.
- CNT_W=2, overlap=1, PATTERN=2'b11, stream of eight 1s: 7 hits; match_cnt saturates at 3 and holds.
